cipher_stream_ctrl: RTL and testbench
=====================================

# cipher_stream_ctrl

Two-requester scheduler for the LFSR-keyed XOR stream cipher datapath. It arbitrates whole messages from two byte sources round-robin and reseeds the keystream generator with the granted channel's seed at message start. It advances the keystream only on accepted bytes and presents ciphertext on a single registered valid/ready output. It sits between byte producers (UART or testbench feeders) and the downstream link, so one encryptor is shared without keystream desynchronisation.

## Interface
- SEED0, 8'hAA, LFSR seed loaded at start of every channel-0 message; value 0 is replaced by 8'h01.
- SEED1, 8'h5C, LFSR seed for channel 1; same zero rule.
- MAX_LEN, 256, maximum bytes per message (range 1..65535); forced termination at this count.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-channel byte valid; bit i = channel i.
- req_data  input  16  per-channel byte; channel i on bits [8i+7:8i].
- req_last  input  2  per-channel marker for the final byte of a message.
- req_ready  output  2  per-channel accept; at most one bit high.
- out_valid  output  1  ciphertext byte valid.
- out_data  output  8  ciphertext (request byte XOR keystream).
- out_last  output  1  final byte of message.
- out_chan  output  1  channel that owns out_data.
- out_ready  input  1  downstream accept.
- busy  output  1  high in STREAM or DRAIN.
- trunc_err  output  1  one-cycle pulse when a message is cut at MAX_LEN.

## Operation
- Keystream: internal 8-bit Fibonacci LFSR `ks`; next = {ks[6:0], ks[7]^ks[5]^ks[4]^ks[3]}. Byte k of a message (k from 0) is XORed with the state after k advances from the seed, so byte 0 uses the seed itself.
- Accept = req_valid[g] & req_ready[g], where g is the granted channel. `ks` advances exactly once per accept and never otherwise.
- FSM states are IDLE, STREAM and DRAIN.
- IDLE: req_ready = 0. If any req_valid bit is set, grant one channel:
  - If only one is valid, grant it.
  - If both are valid, grant the channel other than `last_grant`.
  - On grant, load `ks` with that channel's seed, clear the byte counter and go to STREAM.
- STREAM: req_ready[g] = (!out_valid | out_ready). On accept, register out_data = req_data[g]^ks, out_chan = g and out_valid = 1, then increment the counter.
  - out_last = req_last[g] | (count == MAX_LEN-1).
  - If the counter hit MAX_LEN without req_last, pulse trunc_err in the same cycle as the register load.
  - On an accept with out_last = 1, go to DRAIN.
- DRAIN: req_ready = 0. When out_valid & out_ready & out_last, set last_grant = g and go to IDLE.
- Output register: out_valid clears on out_ready when there is no same-cycle accept. It holds data stable while out_valid & !out_ready.
- Requesters may drop req_valid mid-message. The grant persists and the message continues when valid returns; there is no timeout.
- The counter is 16 bits and never wraps, because it is bounded by MAX_LEN.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_chan 0, req_ready 0, busy 0, trunc_err 0, state IDLE, last_grant 1 (so channel 0 wins the first tie), `ks` = SEED0.
- Reset asserted mid-message aborts immediately. The partial message is lost and no out_last is emitted.
- Grant latency: request seen in IDLE at cycle N; req_ready[g] can be high at N+1.
- Data latency: a byte accepted at edge N appears on out_data after edge N, i.e. 1 cycle.
- Throughput is 1 byte/cycle with out_ready held high.
- Inter-message gap: at least 2 idle output cycles after the last byte (the DRAIN exit edge, then the IDLE grant edge).
- Back-to-back: if both channels hold req_valid continuously, messages alternate 0,1,0,1.

## Test plan
- Ch0 only, SEED0 = AA, bytes 48, 69, 00 (last on 00), out_ready = 1 -> out_data E2, 3C, AB on consecutive cycles; out_last only on AB; out_chan 0.
- Both channels request in the same cycle after reset, each sending 2-byte messages -> ch0 is served first, then ch1 (with `ks` reloaded to SEED1), then ch0 again with the keystream restarted at AA.
- out_ready held low for 3 cycles mid-message -> out_data stable, req_ready low, `ks` frozen; the stream resumes with no skipped keystream values.
- MAX_LEN = 4, ch1 sends 6 bytes with no req_last -> 4 bytes are output, out_last on the 4th, trunc_err pulses once; the remaining 2 bytes start a new ch1 message (if ch0 is idle) keyed from SEED1.
- reset_n pulsed low during the 2nd byte of a message -> all outputs are at reset values asynchronously; the next message starts from the seed.
- Loopback: ch0 output fed to a second cipher_stream_ctrl with the same SEED0 -> the original plaintext bytes are recovered.

Source files
------------

// File: rtl/cipher_stream_ctrl.sv
// rtl/cipher_stream_ctrl.sv - two-channel message scheduler for the LFSR-keyed XOR stream cipher
module cipher_stream_ctrl #(
    parameter logic [7:0]  SEED0   = 8'hAA,
    parameter logic [7:0]  SEED1   = 8'h5C,
    parameter int unsigned MAX_LEN = 256
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    input  logic [1:0]  req_last_i,
    output logic [1:0]  req_ready_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    output logic        out_last_o,
    output logic        out_chan_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        trunc_err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]  SEED0_EFF = (SEED0 == 8'h00) ? 8'h01 : SEED0;
    localparam logic [7:0]  SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
    localparam logic [15:0] LAST_IDX  = 16'(MAX_LEN - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  ks_q, ks_d;
    logic [15:0] cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        out_chan_q, out_chan_d;
    logic        trunc_q, trunc_d;

    logic [7:0]  req_byte;
    logic        req_v;
    logic        req_l;
    logic        out_free;
    logic        accept;
    logic        at_limit;
    logic        msg_end;
    logic        out_done;
    logic        any_req;
    logic        pick;
    logic [7:0]  ks_next;

    assign req_byte = grant_q ? req_data_i[15:8] : req_data_i[7:0];
    assign req_v    = req_valid_i[grant_q];
    assign req_l    = req_last_i[grant_q];
    assign out_free = !out_valid_q || out_ready_i;
    assign accept   = (state_q == S_STREAM) && req_v && out_free;
    assign at_limit = (cnt_q == LAST_IDX);
    assign msg_end  = req_l || at_limit;
    assign out_done = out_valid_q && out_ready_i && out_last_q;
    assign any_req  = |req_valid_i;
    assign pick     = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
    assign ks_next  = {ks_q[6:0], ks_q[7] ^ ks_q[5] ^ ks_q[4] ^ ks_q[3]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && msg_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 2'b00;
        busy_o      = (state_q != S_IDLE);
        if (state_q == S_STREAM) begin
            req_ready_o[grant_q] = out_free;
        end
    end

    // The keystream advances only on an accepted byte, so stalls never desync it.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ks_d         = ks_q;
        cnt_d        = cnt_q;
        if (state_q == S_IDLE && any_req) begin
            grant_d = pick;
            ks_d    = pick ? SEED1_EFF : SEED0_EFF;
            cnt_d   = 16'd0;
        end
        if (accept) begin
            ks_d  = ks_next;
            cnt_d = cnt_q + 16'd1;
        end
        if (state_q == S_DRAIN && out_done) begin
            last_grant_d = grant_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        trunc_d     = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = req_byte ^ ks_q;
            out_last_d  = msg_end;
            out_chan_d  = grant_q;
            trunc_d     = at_limit && !req_l;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ks_q         <= SEED0_EFF;
            cnt_q        <= 16'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            out_chan_q   <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ks_q         <= ks_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_chan_q   <= out_chan_d;
            trunc_q      <= trunc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_chan_o  = out_chan_q;
    assign trunc_err_o = trunc_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// tb/tb_cipher_stream_ctrl.sv - directed self-checking bench for cipher_stream_ctrl
module tb_cipher_stream_ctrl;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        chan;
        logic        trunc;
        logic [31:0] cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00;
    logic        ordy = 1'b1;
    logic        loop_mode = 1'b0;
    logic        tmode = 1'b0;

    logic [1:0]  m_rr, t_rr, lb_rr;
    logic        m_ov, m_ol, m_oc, m_busy, m_te, m_ordy;
    logic [7:0]  m_od;
    logic        t_ov, t_ol, t_oc, t_busy, t_te;
    logic [7:0]  t_od;
    logic        lb_ov, lb_ol, lb_oc, lb_busy, lb_te;
    logic [7:0]  lb_od;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   t_trunc_cnt = 0;
    ent_t log_m[$];
    ent_t log_t[$];
    ent_t log_l[$];

    assign m_ordy = loop_mode ? lb_rr[0] : ordy;

    cipher_stream_ctrl dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i({v1, v0}), .req_data_i({d1, d0}), .req_last_i({l1, l0}),
        .req_ready_o(m_rr), .out_valid_o(m_ov), .out_data_o(m_od), .out_last_o(m_ol),
        .out_chan_o(m_oc), .out_ready_i(m_ordy), .busy_o(m_busy), .trunc_err_o(m_te)
    );

    cipher_stream_ctrl #(.MAX_LEN(4)) dut_t (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i({v1, v0}), .req_data_i({d1, d0}), .req_last_i({l1, l0}),
        .req_ready_o(t_rr), .out_valid_o(t_ov), .out_data_o(t_od), .out_last_o(t_ol),
        .out_chan_o(t_oc), .out_ready_i(1'b1), .busy_o(t_busy), .trunc_err_o(t_te)
    );

    cipher_stream_ctrl dut_lb (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i({1'b0, loop_mode & m_ov}), .req_data_i({8'h00, m_od}),
        .req_last_i({1'b0, m_ol}),
        .req_ready_o(lb_rr), .out_valid_o(lb_ov), .out_data_o(lb_od), .out_last_o(lb_ol),
        .out_chan_o(lb_oc), .out_ready_i(1'b1), .busy_o(lb_busy), .trunc_err_o(lb_te)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        #2;
        if (m_ov && m_ordy) log_m.push_back(ent_t'{m_od, m_ol, m_oc, m_te, 32'(cyc)});
        if (t_ov) log_t.push_back(ent_t'{t_od, t_ol, t_oc, t_te, 32'(cyc)});
        if (lb_ov) log_l.push_back(ent_t'{lb_od, lb_ol, lb_oc, lb_te, 32'(cyc)});
        if (t_te) t_trunc_cnt = t_trunc_cnt + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one byte on a channel and hold it until the selected DUT accepts it.
    task automatic send_byte(input logic ch, input logic [7:0] d, input logic l);
        int n;
        @(negedge clk);
        if (ch) begin v1 = 1'b1; d1 = d; l1 = l; end
        else    begin v0 = 1'b1; d0 = d; l0 = l; end
        n = 0;
        #1;
        while (!(tmode ? t_rr[ch] : m_rr[ch])) begin
            if (n >= 100) begin
                checks++;
                $display("FAIL send_timeout ch=%0d byte=%h req_ready never high", ch, d);
                if (ch) v1 = 1'b0; else v0 = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        if (ch) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++; if (m_ov !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", m_ov); else passes++;
        checks++; if (m_od !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", m_od); else passes++;
        checks++; if (m_ol !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", m_ol); else passes++;
        checks++; if (m_oc !== 1'b0) $display("FAIL reset_out_chan got=%b exp=0", m_oc); else passes++;
        checks++; if (m_rr !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", m_rr); else passes++;
        checks++; if (m_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", m_busy); else passes++;
        checks++; if (m_te !== 1'b0) $display("FAIL reset_trunc got=%b exp=0", m_te); else passes++;
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        int n;
        exp_d = '{8'hE2, 8'h3C, 8'hAB};
        log_m.delete();
        ordy = 1'b1;
        send_byte(1'b0, 8'h48, 1'b0);
        checks++; if (m_busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", m_busy); else passes++;
        send_byte(1'b0, 8'h69, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1);
        n = 0;
        while (log_m.size() < 3 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (log_m.size() < 3) begin
            $display("FAIL single_count got=%0d exp=3", log_m.size());
            return;
        end
        passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_m[i].data !== exp_d[i]) $display("FAIL single_data[%0d] got=%h exp=%h", i, log_m[i].data, exp_d[i]); else passes++;
            checks++; if (log_m[i].last !== (i == 2)) $display("FAIL single_last[%0d] got=%b exp=%b", i, log_m[i].last, (i == 2)); else passes++;
            checks++; if (log_m[i].chan !== 1'b0) $display("FAIL single_chan[%0d] got=%b exp=0", i, log_m[i].chan); else passes++;
            if (i > 0) begin
                checks++; if (log_m[i].cyc - log_m[i-1].cyc !== 32'd1) $display("FAIL single_gap[%0d] got=%0d exp=1", i, log_m[i].cyc - log_m[i-1].cyc); else passes++;
            end
        end
        n = 0;
        while (m_busy && n < 10) begin @(negedge clk); n++; end
        checks++; if (m_busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", m_busy); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [6];
        logic       exp_c [6];
        int n;
        exp_d = '{8'hBB, 8'h77, 8'h6F, 8'hFC, 8'hFF, 8'h33};
        exp_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        log_m.delete();
        fork
            begin
                send_byte(1'b0, 8'h11, 1'b0); send_byte(1'b0, 8'h22, 1'b1);
                send_byte(1'b0, 8'h55, 1'b0); send_byte(1'b0, 8'h66, 1'b1);
            end
            begin
                send_byte(1'b1, 8'h33, 1'b0); send_byte(1'b1, 8'h44, 1'b1);
            end
        join
        n = 0;
        while (log_m.size() < 6 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (log_m.size() < 6) begin
            $display("FAIL tie_count got=%0d exp=6", log_m.size());
            return;
        end
        passes++;
        for (int i = 0; i < 6; i++) begin
            checks++; if (log_m[i].data !== exp_d[i]) $display("FAIL tie_data[%0d] got=%h exp=%h", i, log_m[i].data, exp_d[i]); else passes++;
            checks++; if (log_m[i].chan !== exp_c[i]) $display("FAIL tie_chan[%0d] got=%b exp=%b", i, log_m[i].chan, exp_c[i]); else passes++;
            checks++; if (log_m[i].last !== (i % 2 == 1)) $display("FAIL tie_last[%0d] got=%b exp=%b", i, log_m[i].last, (i % 2 == 1)); else passes++;
        end
        checks++; if (log_m[2].cyc - log_m[1].cyc !== 32'd3) $display("FAIL tie_msg_gap got=%0d exp=3", log_m[2].cyc - log_m[1].cyc); else passes++;
    endtask

    task automatic test_stall();
        logic [7:0] exp_d [5];
        int n;
        exp_d = '{8'hAB, 8'h57, 8'hA8, 8'h53, 8'hAA};
        log_m.delete();
        ordy = 1'b1;
        fork
            begin
                send_byte(1'b0, 8'h01, 1'b0); send_byte(1'b0, 8'h02, 1'b0);
                send_byte(1'b0, 8'h03, 1'b0); send_byte(1'b0, 8'h04, 1'b0);
                send_byte(1'b0, 8'h05, 1'b1);
            end
            begin
                logic [7:0] hold;
                int w;
                w = 0;
                while (log_m.size() < 2 && w < 50) begin @(negedge clk); w++; end
                ordy = 1'b0;
                #1;
                hold = m_od;
                checks++; if (m_ov !== 1'b1) $display("FAIL stall_valid got=%b exp=1", m_ov); else passes++;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) begin @(negedge clk); #1; end
                    checks++; if (m_od !== hold) $display("FAIL stall_data[%0d] got=%h exp=%h", i, m_od, hold); else passes++;
                    checks++; if (m_rr !== 2'b00) $display("FAIL stall_ready[%0d] got=%b exp=00", i, m_rr); else passes++;
                end
                @(negedge clk);
                ordy = 1'b1;
            end
        join
        n = 0;
        while (log_m.size() < 5 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (log_m.size() < 5) begin
            $display("FAIL stall_count got=%0d exp=5", log_m.size());
            return;
        end
        passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (log_m[i].data !== exp_d[i]) $display("FAIL stall_out[%0d] got=%h exp=%h", i, log_m[i].data, exp_d[i]); else passes++;
        end
        checks++; if (log_m[4].cyc - log_m[0].cyc !== 32'd7) $display("FAIL stall_span got=%0d exp=7", log_m[4].cyc - log_m[0].cyc); else passes++;
    endtask

    task automatic test_trunc();
        logic [7:0] exp_d [6];
        logic [7:0] in_d [6];
        int n;
        exp_d = '{8'h4C, 8'h98, 8'h40, 8'hA0, 8'h0C, 8'hD8};
        in_d  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        do_reset();
        tmode = 1'b1;
        log_t.delete();
        t_trunc_cnt = 0;
        for (int i = 0; i < 6; i++) send_byte(1'b1, in_d[i], 1'b0);
        n = 0;
        while (log_t.size() < 6 && n < 20) begin @(negedge clk); n++; end
        tmode = 1'b0;
        checks++;
        if (log_t.size() < 6) begin
            $display("FAIL trunc_count got=%0d exp=6", log_t.size());
            return;
        end
        passes++;
        for (int i = 0; i < 6; i++) begin
            checks++; if (log_t[i].data !== exp_d[i]) $display("FAIL trunc_data[%0d] got=%h exp=%h", i, log_t[i].data, exp_d[i]); else passes++;
            checks++; if (log_t[i].last !== (i == 3)) $display("FAIL trunc_last[%0d] got=%b exp=%b", i, log_t[i].last, (i == 3)); else passes++;
            checks++; if (log_t[i].trunc !== (i == 3)) $display("FAIL trunc_flag[%0d] got=%b exp=%b", i, log_t[i].trunc, (i == 3)); else passes++;
            checks++; if (log_t[i].chan !== 1'b1) $display("FAIL trunc_chan[%0d] got=%b exp=1", i, log_t[i].chan); else passes++;
        end
        checks++; if (t_trunc_cnt !== 1) $display("FAIL trunc_pulses got=%0d exp=1", t_trunc_cnt); else passes++;
        checks++; if (log_t[4].cyc - log_t[3].cyc !== 32'd3) $display("FAIL trunc_gap got=%0d exp=3", log_t[4].cyc - log_t[3].cyc); else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        log_m.delete();
        ordy = 1'b1;
        send_byte(1'b0, 8'h48, 1'b0);
        @(negedge clk);
        v0 = 1'b1; d0 = 8'h69; l0 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (m_ov !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", m_ov); else passes++;
        checks++; if (m_od !== 8'h00) $display("FAIL mid_out_data got=%h exp=00", m_od); else passes++;
        checks++; if (m_ol !== 1'b0) $display("FAIL mid_out_last got=%b exp=0", m_ol); else passes++;
        checks++; if (m_oc !== 1'b0) $display("FAIL mid_out_chan got=%b exp=0", m_oc); else passes++;
        checks++; if (m_rr !== 2'b00) $display("FAIL mid_req_ready got=%b exp=00", m_rr); else passes++;
        checks++; if (m_busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", m_busy); else passes++;
        v0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(1'b0, 8'h7E, 1'b0);
        send_byte(1'b0, 8'h3F, 1'b1);
        n = 0;
        while (log_m.size() < 3 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (log_m.size() !== 3) begin
            $display("FAIL mid_count got=%0d exp=3", log_m.size());
            return;
        end
        passes++;
        checks++; if (log_m[0].data !== 8'hE2 || log_m[0].last !== 1'b0) $display("FAIL mid_first got=%h/%b exp=e2/0", log_m[0].data, log_m[0].last); else passes++;
        checks++; if (log_m[1].data !== 8'hD4 || log_m[1].last !== 1'b0) $display("FAIL mid_restart0 got=%h/%b exp=d4/0", log_m[1].data, log_m[1].last); else passes++;
        checks++; if (log_m[2].data !== 8'h6A || log_m[2].last !== 1'b1) $display("FAIL mid_restart1 got=%h/%b exp=6a/1", log_m[2].data, log_m[2].last); else passes++;
    endtask

    task automatic test_loopback();
        logic [7:0] exp_d [3];
        int n;
        exp_d = '{8'h48, 8'h69, 8'h00};
        do_reset();
        loop_mode = 1'b1;
        log_l.delete();
        send_byte(1'b0, 8'h48, 1'b0);
        send_byte(1'b0, 8'h69, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1);
        n = 0;
        while (log_l.size() < 3 && n < 60) begin @(negedge clk); n++; end
        loop_mode = 1'b0;
        checks++;
        if (log_l.size() < 3) begin
            $display("FAIL loop_count got=%0d exp=3", log_l.size());
            return;
        end
        passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_l[i].data !== exp_d[i]) $display("FAIL loop_data[%0d] got=%h exp=%h", i, log_l[i].data, exp_d[i]); else passes++;
            checks++; if (log_l[i].last !== (i == 2)) $display("FAIL loop_last[%0d] got=%b exp=%b", i, log_l[i].last, (i == 2)); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_trunc();
        test_reset_mid();
        test_loopback();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
